// File: rtl/pu_vec_alu_pkg.sv
// Shared function codes and saturation-bound helpers for the PU vector ALU.
package pu_vec_alu_pkg;

  localparam logic [1:0] FN_PASS = 2'd0;
  localparam logic [1:0] FN_MUL  = 2'd1;
  localparam logic [1:0] FN_RELU = 2'd2;
  localparam logic [1:0] FN_MAX  = 2'd3;

  function automatic logic signed [63:0] sat_smax(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] sat_smin(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

  function automatic logic signed [63:0] sat_umax(input int w);
    return (64'sd1 <<< w) - 64'sd1;
  endfunction

endpackage

// File: rtl/pu_vec_alu_lane.sv
// One accumulator lane: S1 product/shift register, S2 round/saturate and
// running-max accumulator. The S2 result is registered by the top level.
module pu_vec_alu_lane
  import pu_vec_alu_pkg::*;
#(
  parameter int LANE_WIDTH  = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int OUT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_adv,
  input  logic [LANE_WIDTH-1:0]  i_x,
  input  logic [IMM_WIDTH-1:0]   i_imm,
  input  logic [SHIFT_WIDTH-1:0] i_shift,
  input  logic [1:0]             i_fn,
  input  logic [1:0]             i_s1_fn,
  input  logic [SHIFT_WIDTH-1:0] i_s1_shift,
  input  logic                   i_acc_en,
  input  logic                   i_acc_first,
  input  logic                   i_acc_clr,
  output logic [LANE_WIDTH-1:0]  o_y
);

  localparam int PW = LANE_WIDTH + IMM_WIDTH;
  localparam logic signed [63:0] L_SMAX = sat_smax(OUT_WIDTH);
  localparam logic signed [63:0] L_SMIN = sat_smin(OUT_WIDTH);
  localparam logic signed [63:0] L_UMAX = sat_umax(OUT_WIDTH);

  logic signed [LANE_WIDTH-1:0] w_x;
  logic signed [IMM_WIDTH-1:0]  w_imm;
  logic signed [PW-1:0]         w_prod;
  logic signed [PW-1:0]         r_p;
  logic signed [PW-1:0]         w_half;
  logic signed [PW-1:0]         w_bias;
  logic signed [PW-1:0]         w_sum;
  logic signed [PW-1:0]         w_rnd;
  logic signed [63:0]           w_r64;
  logic signed [LANE_WIDTH-1:0] w_pass;
  logic signed [LANE_WIDTH-1:0] w_sat;
  logic signed [LANE_WIDTH-1:0] w_max;
  logic signed [LANE_WIDTH-1:0] r_acc;

  assign w_x   = i_x;
  assign w_imm = i_imm;

  // PASS/MAX share the S1 register with the product, sign-extended to full width.
  always_comb begin
    if (i_fn == FN_MUL || i_fn == FN_RELU) begin
      w_prod = PW'(w_x) * PW'(w_imm);
    end else begin
      w_prod = PW'(w_x >>> i_shift);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_p <= '0;
    end else if (i_adv) begin
      r_p <= w_prod;
    end
  end

  // Round half away from zero: negative values get one less than the half LSB.
  assign w_half = PW'(1) << (i_s1_shift - SHIFT_WIDTH'(1));
  assign w_bias = (i_s1_shift == '0) ? '0 : (r_p[PW-1] ? w_half - PW'(1) : w_half);
  assign w_sum  = r_p + w_bias;
  assign w_rnd  = w_sum >>> i_s1_shift;
  assign w_r64  = 64'(w_rnd);
  assign w_pass = r_p[LANE_WIDTH-1:0];

  always_comb begin
    w_sat = w_rnd[LANE_WIDTH-1:0];
    if (i_s1_fn == FN_RELU) begin
      if (w_r64 < 64'sd0) begin
        w_sat = '0;
      end else if (w_r64 > L_UMAX) begin
        w_sat = L_UMAX[LANE_WIDTH-1:0];
      end
    end else begin
      if (w_r64 > L_SMAX) begin
        w_sat = L_SMAX[LANE_WIDTH-1:0];
      end else if (w_r64 < L_SMIN) begin
        w_sat = L_SMIN[LANE_WIDTH-1:0];
      end
    end
  end

  assign w_max = (i_acc_first || (w_pass > r_acc)) ? w_pass : r_acc;

  always_ff @(posedge clk) begin
    if (reset || i_acc_clr) begin
      r_acc <= '0;
    end else if (i_acc_en) begin
      r_acc <= w_max;
    end
  end

  always_comb begin
    o_y = w_pass;
    if (i_s1_fn == FN_MUL || i_s1_fn == FN_RELU) begin
      o_y = w_sat;
    end else if (i_s1_fn == FN_MAX) begin
      o_y = w_max;
    end
  end

endmodule

// File: rtl/pu_vec_alu.sv
// PU vector post-processing ALU: handshake, configuration, MAX window
// counter and busy tracking around NUM_LANES independent lane datapaths.
module pu_vec_alu
  import pu_vec_alu_pkg::*;
#(
  parameter int NUM_LANES   = 2,
  parameter int LANE_WIDTH  = 32,
  parameter int IMM_WIDTH   = 16,
  parameter int SHIFT_WIDTH = 6,
  parameter int OUT_WIDTH   = 8,
  parameter int POOL_WIDTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            cfg_v,
  input  logic [1:0]                      cfg_fn,
  input  logic [IMM_WIDTH-1:0]            cfg_imm,
  input  logic [SHIFT_WIDTH-1:0]          cfg_shift,
  input  logic [POOL_WIDTH-1:0]           cfg_pool,
  output logic                            cfg_err,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [NUM_LANES*LANE_WIDTH-1:0] in_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_LANES*LANE_WIDTH-1:0] out_data,
  output logic                            busy
);

  logic [1:0]                      r_fn;
  logic [IMM_WIDTH-1:0]            r_imm;
  logic [SHIFT_WIDTH-1:0]          r_shift;
  logic [POOL_WIDTH-1:0]           r_pool;
  logic                            r_cfg_err;
  logic [POOL_WIDTH-1:0]           r_cnt;
  logic                            r_s1_valid;
  logic [1:0]                      r_s1_fn;
  logic [SHIFT_WIDTH-1:0]          r_s1_shift;
  logic                            r_s1_first;
  logic                            r_s1_last;
  logic                            r_out_valid;
  logic [NUM_LANES*LANE_WIDTH-1:0] r_out_data;

  logic                            w_adv;
  logic                            w_accept;
  logic                            w_busy;
  logic                            w_cfg_load;
  logic [POOL_WIDTH-1:0]           w_pool_eff;
  logic                            w_first;
  logic                            w_last;
  logic                            w_emit;
  logic                            w_acc_en;
  logic [NUM_LANES*LANE_WIDTH-1:0] w_lane_y;

  assign w_adv      = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_adv;
  assign w_busy     = r_s1_valid || r_out_valid || (r_cnt != '0);
  assign w_cfg_load = cfg_v && !w_busy;
  assign w_pool_eff = (r_pool == '0) ? POOL_WIDTH'(1) : r_pool;
  assign w_first    = (r_cnt == '0);
  assign w_last     = (r_cnt == w_pool_eff - POOL_WIDTH'(1));
  // Only the last word of a MAX window leaves the pipeline as an output.
  assign w_emit     = r_s1_valid && ((r_s1_fn != FN_MAX) || r_s1_last);
  assign w_acc_en   = r_s1_valid && w_adv && (r_s1_fn == FN_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fn    <= FN_PASS;
      r_imm   <= IMM_WIDTH'(1);
      r_shift <= '0;
      r_pool  <= POOL_WIDTH'(1);
    end else if (w_cfg_load) begin
      r_fn    <= cfg_fn;
      r_imm   <= cfg_imm;
      r_shift <= cfg_shift;
      r_pool  <= cfg_pool;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cfg_err <= 1'b0;
    end else begin
      r_cfg_err <= cfg_v && w_busy;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || w_cfg_load) begin
      r_cnt <= '0;
    end else if (w_accept && (r_fn == FN_MAX)) begin
      r_cnt <= w_last ? '0 : r_cnt + POOL_WIDTH'(1);
    end
  end

  // Function and shift travel with the word so a config load cannot alter S2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_fn    <= FN_PASS;
      r_s1_shift <= '0;
      r_s1_first <= 1'b0;
      r_s1_last  <= 1'b0;
    end else if (w_adv) begin
      r_s1_valid <= in_valid;
      r_s1_fn    <= r_fn;
      r_s1_shift <= r_shift;
      r_s1_first <= w_first;
      r_s1_last  <= w_last;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_adv) begin
      r_out_valid <= w_emit;
      if (w_emit) begin
        r_out_data <= w_lane_y;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      pu_vec_alu_lane #(
        .LANE_WIDTH (LANE_WIDTH),
        .IMM_WIDTH  (IMM_WIDTH),
        .SHIFT_WIDTH(SHIFT_WIDTH),
        .OUT_WIDTH  (OUT_WIDTH)
      ) u_lane (
        .clk        (clk),
        .reset      (reset),
        .i_adv      (w_adv),
        .i_x        (in_data[gi*LANE_WIDTH +: LANE_WIDTH]),
        .i_imm      (r_imm),
        .i_shift    (r_shift),
        .i_fn       (r_fn),
        .i_s1_fn    (r_s1_fn),
        .i_s1_shift (r_s1_shift),
        .i_acc_en   (w_acc_en),
        .i_acc_first(r_s1_first),
        .i_acc_clr  (w_cfg_load),
        .o_y        (w_lane_y[gi*LANE_WIDTH +: LANE_WIDTH])
      );
    end
  endgenerate

  assign in_ready  = w_adv;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign busy      = w_busy;
  assign cfg_err   = r_cfg_err;

endmodule

// File: tb/tb_pu_vec_alu.sv
// Directed bench for pu_vec_alu with hand-computed expected results.
module tb_pu_vec_alu;
  import pu_vec_alu_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cfg_v;
  logic [1:0]  cfg_fn;
  logic [15:0] cfg_imm;
  logic [5:0]  cfg_shift;
  logic [3:0]  cfg_pool;
  logic        cfg_err;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        busy;

  int checks = 0;
  int errors = 0;

  pu_vec_alu dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_v    (cfg_v),
    .cfg_fn   (cfg_fn),
    .cfg_imm  (cfg_imm),
    .cfg_shift(cfg_shift),
    .cfg_pool (cfg_pool),
    .cfg_err  (cfg_err),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [63:0] pk(input int a, input int b);
    return {b[31:0], a[31:0]};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_cfg(input logic [1:0] fn, input int imm, input int sh, input int pool);
    cfg_fn    = fn;
    cfg_imm   = 16'(imm);
    cfg_shift = 6'(sh);
    cfg_pool  = 4'(pool);
    cfg_v     = 1'b1;
    cyc;
    cfg_v     = 1'b0;
  endtask

  // Single word: checks exact two-cycle latency, then lets the output drain.
  task automatic xfer(input int a, input int b, input logic [63:0] exp, input string tag);
    in_valid = 1'b1;
    in_data  = pk(a, b);
    cyc;
    in_valid = 1'b0;
    chk({tag, "_lat1"}, {63'd0, out_valid}, 64'd0);
    cyc;
    chk({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({tag, "_data"}, out_data, exp);
    $display("xfer %s in=(%0d,%0d) out=%h", tag, a, b, out_data);
    cyc;
  endtask

  int          l0[6] = '{4, -2, 9, 1, 1, 1};
  int          l1[6] = '{-1, -5, -3, 0, 2, -7};
  int          si;
  int          ri;
  logic [63:0] held;
  bit          holding;

  initial begin
    reset = 1'b1; cfg_v = 1'b0; cfg_fn = '0; cfg_imm = '0; cfg_shift = '0; cfg_pool = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    cyc; cyc;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    reset = 1'b0;
    cyc;

    do_cfg(FN_PASS, 1, 3, 1);
    xfer(-100, 100, pk(-13, 12), "pass_sh3");

    do_cfg(FN_MUL, 1, 2, 1);
    xfer(-37, -38, pk(-9, -10), "mul_round");

    do_cfg(FN_MUL, 3, 4, 1);
    xfer(1000, -1000, pk(127, -128), "mul_sat");

    do_cfg(FN_RELU, 1, 0, 1);
    xfer(-5, 300, pk(0, 255), "relu_clamp");
    do_cfg(FN_RELU, 1, 1, 1);
    xfer(5, 7, pk(3, 4), "relu_round");

    // MAX pool=3: outputs after the 3rd and 6th accepted words only.
    do_cfg(FN_MAX, 1, 0, 3);
    for (int k = 1; k <= 8; k++) begin
      if (k <= 6) begin
        in_valid = 1'b1;
        in_data  = pk(l0[k-1], l1[k-1]);
      end else begin
        in_valid = 1'b0;
      end
      cyc;
      chk($sformatf("max_valid_%0d", k), {63'd0, out_valid}, (k == 4 || k == 7) ? 64'd1 : 64'd0);
      if (k == 4) chk("max_win1", out_data, pk(9, -1));
      if (k == 7) chk("max_win2", out_data, pk(1, 2));
      if (k <= 2) chk($sformatf("max_busy_%0d", k), {63'd0, busy}, 64'd1);
      $display("max step %0d out_valid=%0b out=%h busy=%0b", k, out_valid, out_data, busy);
    end
    in_valid = 1'b0;
    chk("max_idle_busy", {63'd0, busy}, 64'd0);

    // Back-pressure: out_ready low for 5 cycles during a 10-word burst.
    do_cfg(FN_MUL, 2, 1, 1);
    si = 0; ri = 0; holding = 1'b0; held = '0;
    for (int c = 0; c < 60 && ri < 10; c++) begin
      out_ready = !(c >= 4 && c < 9);
      in_valid  = (si < 10);
      in_data   = pk(si * 5 - 20, -si);
      #1;
      if (out_valid && !out_ready) begin
        chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        if (holding) chk("bp_hold", out_data, held);
        held = out_data;
        holding = 1'b1;
      end else begin
        holding = 1'b0;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("bp_word_%0d", ri), out_data, pk(ri * 5 - 20, -ri));
        $display("bp recv %0d out=%h", ri, out_data);
        ri++;
      end
      if (in_valid && in_ready) si++;
      cyc;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("bp_count", 64'(ri), 64'd10);
    cyc; cyc;

    // Config attempt while a MAX window is open must be rejected.
    do_cfg(FN_MAX, 1, 0, 2);
    in_valid = 1'b1; in_data = pk(3, -4);
    cyc;
    in_valid = 1'b0;
    cfg_fn = FN_PASS; cfg_shift = 6'd0; cfg_pool = 4'd1; cfg_v = 1'b1;
    cyc;
    cfg_v = 1'b0;
    chk("cfgerr_pulse", {63'd0, cfg_err}, 64'd1);
    chk("cfgerr_noout", {63'd0, out_valid}, 64'd0);
    in_valid = 1'b1; in_data = pk(8, -9);
    cyc;
    in_valid = 1'b0;
    chk("cfgerr_clear", {63'd0, cfg_err}, 64'd0);
    chk("cfgerr_noout2", {63'd0, out_valid}, 64'd0);
    cyc;
    chk("cfgerr_kept_valid", {63'd0, out_valid}, 64'd1);
    chk("cfgerr_kept_data", out_data, pk(8, -4));
    $display("cfgerr window out=%h", out_data);
    cyc;

    // Reset in the middle of a MAX window.
    in_valid = 1'b1; in_data = pk(7, 7);
    cyc;
    in_valid = 1'b0;
    chk("midrst_busy_before", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    cyc;
    chk("midrst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst_busy", {63'd0, busy}, 64'd0);
    reset = 1'b0;
    cyc;
    chk("midrst_no_out", {63'd0, out_valid}, 64'd0);
    xfer(55, -55, pk(55, -55), "post_rst_pass");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_vec_alu.md
# pu_vec_alu

Parametrised vector post-processing ALU for the processing unit (PU), placed between the output-buffer read path and the PU store path. It applies one configured function per output word to each of NUM_LANES accumulator lanes:
- pass-through with arithmetic shift;
- requantise: multiply, rounding shift, signed saturate;
- requantise with ReLU clamp;
- running max over a programmable pool window.

It has a valid/ready stream interface and a fixed-latency two-stage pipeline.

## Interface
Parameters:
- NUM_LANES, 2, number of independent accumulator lanes.
- LANE_WIDTH, 32, signed accumulator width per lane.
- IMM_WIDTH, 16, signed multiplier width.
- SHIFT_WIDTH, 6, right-shift amount width.
- OUT_WIDTH, 8, saturation width for the MUL and RELU functions.
- POOL_WIDTH, 4, pool-size counter width.

Ports (clock and reset first):
- clk  in  1  single clock; all logic is synchronous to it.
- reset  in  1  synchronous, active-high.
- cfg_v  in  1  configuration load strobe.
- cfg_fn  in  2  function select: 0 PASS, 1 MUL, 2 RELU, 3 MAX.
- cfg_imm  in  IMM_WIDTH  signed multiplier.
- cfg_shift  in  SHIFT_WIDTH  right-shift amount, 0..LANE_WIDTH-1.
- cfg_pool  in  POOL_WIDTH  MAX window length; 0 is treated as 1.
- cfg_err  out  1  one-cycle pulse when cfg_v arrives while busy.
- in_valid  in  1  input word valid.
- in_ready  out  1  input accepted when in_valid && in_ready.
- in_data  in  NUM_LANES*LANE_WIDTH  lane i occupies bits [i*LANE_WIDTH +: LANE_WIDTH].
- out_valid  out  1  output word valid.
- out_ready  in  1  downstream accept.
- out_data  out  NUM_LANES*LANE_WIDTH  per-lane results, same packing as in_data.
- busy  out  1  a word is held in the pipeline, or a MAX window is partially accumulated.

## Operation
- Configuration registers load on cfg_v only when busy=0. When busy=1, cfg_v is ignored and cfg_err pulses. A successful load clears the MAX counter and accumulators.
- Per-lane datapath for x (signed LANE_WIDTH), m = cfg_imm, s = cfg_shift:
  - PASS: y = x >>> s. No rounding, no saturation.
  - MUL: p = x*m (LANE_WIDTH+IMM_WIDTH bits, full precision). Round half away from zero: if s>0, add 2^(s-1) when p≥0 and 2^(s-1)-1 when p<0, then >>> s. Saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. Sign-extend to LANE_WIDTH.
  - RELU: same as MUL, but clamp to [0, 2^OUT_WIDTH-1] and zero-extend.
  - MAX: the PASS result feeds a per-lane signed running max. The counter counts accepted words 0..P-1, where P = max(cfg_pool,1). The first word of a window loads the accumulator; later words keep the larger value. Only the P-th word produces an output, which is the window max. The counter then wraps to 0.
- Lanes are fully independent; there is no cross-lane carry.

## Timing
- Pipeline: S1 registers the product (or the shifted x for PASS/MAX). S2 registers the rounded, saturated, or max result into the output register.
- Latency: an input accepted at cycle t appears on out_data with out_valid at t+2 when there is no stall.
- Global stall: adv = !out_valid || out_ready. in_ready = adv. Both stages hold while adv=0. out_data is stable while out_valid && !out_ready.
- Throughput: one word per cycle while out_ready=1. In MAX mode, one output per P accepted inputs.
- Non-final MAX words advance through S1 but do not set out_valid.
- Reset values: out_valid=0, out_data=0, in_ready=1, busy=0, cfg_err=0. Stage valids, MAX counter and accumulators are 0. Config registers: fn=PASS, imm=1, shift=0, pool=1.
- Reset mid-stream discards in-flight words and any partial MAX window. There is no output on the following cycle.
- Simultaneous cfg_v and in_valid with busy=0: the word is accepted and processed with the old configuration. The new configuration takes effect on the next cycle.

## Structure
- Package pu_vec_alu_pkg holds FN_PASS/FN_MUL/FN_RELU/FN_MAX localparams and the saturation-bound helper constants.
- Sub-module pu_vec_alu_lane holds the per-lane multiply/round/saturate datapath. The top level generates NUM_LANES instances and owns the handshake, configuration, MAX counter and busy logic.

## Test plan
- MUL, imm=1, shift=2, lane0=-37, lane1=-38 → -9 and -10, sign-extended. Latency is exactly 2 cycles.
- MUL, imm=3, shift=4, lane0=1000, lane1=-1000 → 127 and -128 (saturation).
- RELU, imm=1, shift=0, lanes -5 and 300 → 0 and 255. Then shift=1 on 5 → 3 (rounding half up).
- MAX, pool=3, lane0 inputs 4, -2, 9, 1, 1, 1 → exactly two outputs: 9, then 1. busy=1 between the first and third inputs.
- Back-pressure: hold out_ready=0 for 5 cycles during a 10-word MUL burst. in_ready drops, out_data stays constant, and all 10 results arrive in order with none lost.
- Issue cfg_v while busy=1 → cfg_err pulses for 1 cycle and the configuration is unchanged. Assert reset mid-MAX-window → out_valid=0 and busy=0 on the next cycle.
